sc_reg_bank: RTL and testbench

//  Parametrised bank of NREGS general registers, each DATAWIDTH_BUS bits wide.
//  One write port with per-write operation mode; two independent async read ports.

---
 rtl/sc_regbank_pkg.sv | 8 +
 rtl/sc_reg_cell.sv | 30 +++
 rtl/sc_reg_bank.sv | 71 +++++++
 tb/tb_sc_reg_bank.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sc_regbank_pkg.sv
// sc_regbank_pkg: write-op mode encodings shared by the register bank RTL and its bench.
package sc_regbank_pkg;
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_LOAD = 2'b00;
    localparam mode_t MODE_INC  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_SHR  = 2'b11;
endpackage

// File: rtl/sc_reg_cell.sv
// sc_reg_cell: one bank register plus its op-select next-value and next-flag logic.
module sc_reg_cell
    import sc_regbank_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_we,
    input  mode_t        i_mode,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_next,
    output logic         o_next_flag
);
    logic [W-1:0] r_q;

    assign o_next = i_mode == MODE_LOAD ? i_data :
                    i_mode == MODE_INC  ? r_q + W'(1) :
                    i_mode == MODE_SHL  ? {r_q[W-2:0], 1'b0} : {1'b0, r_q[W-1:1]};
    // INC carries out only when the register was all ones
    assign o_next_flag = i_mode == MODE_LOAD ? 1'b0 :
                         i_mode == MODE_INC  ? &r_q :
                         i_mode == MODE_SHL  ? r_q[W-1] : r_q[0];
    assign o_q = r_q;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_q <= '0;
        else if (i_we) r_q <= o_next;
endmodule

// File: rtl/sc_reg_bank.sv
// sc_reg_bank: NREGS-entry register bank, one op write port, two async read ports, carry flag.
// Define SC_REGBANK_BYPASS_EN to forward the pending op result to matching read ports.
module sc_reg_bank
    import sc_regbank_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 8,
    parameter int NREGS         = 4,
    parameter int ADDRWIDTH     = 2
) (
    input  logic                     SC_RegBANK_CLOCK_50,
    input  logic                     SC_RegBANK_Reset_InLow,
    input  logic                     SC_RegBANK_Write_InLow,
    input  logic [1:0]               SC_RegBANK_Mode_In,
    input  logic [ADDRWIDTH-1:0]     SC_RegBANK_WrAddr_In,
    input  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUS_In,
    input  logic [ADDRWIDTH-1:0]     SC_RegBANK_RdAddrA_In,
    input  logic [ADDRWIDTH-1:0]     SC_RegBANK_RdAddrB_In,
    output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataA_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataB_Out,
    output logic                     SC_RegBANK_ZeroA_Out,
    output logic                     SC_RegBANK_Flag_Out
);
    localparam int NSLOT = 2**ADDRWIDTH;
`ifdef SC_REGBANK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATAWIDTH_BUS-1:0] w_q [NSLOT];
    logic [DATAWIDTH_BUS-1:0] w_nq[NSLOT];
    logic                     w_nf[NSLOT];
    logic                     w_wr_ok, w_fwd_a, w_fwd_b;
    logic                     r_flag;

    // out-of-range write addresses are dropped entirely
    assign w_wr_ok = !SC_RegBANK_Write_InLow &&
                     ({1'b0, SC_RegBANK_WrAddr_In} < (ADDRWIDTH+1)'(NREGS));

    // unpopulated address slots read as zero
    for (genvar i = 0; i < NSLOT; i++) begin : g_cell
        if (i < NREGS) begin : g_reg
            sc_reg_cell #(.W(DATAWIDTH_BUS)) u_cell (
                .i_clk      (SC_RegBANK_CLOCK_50),
                .i_rst_n    (SC_RegBANK_Reset_InLow),
                .i_we       (w_wr_ok && SC_RegBANK_WrAddr_In == ADDRWIDTH'(i)),
                .i_mode     (SC_RegBANK_Mode_In),
                .i_data     (SC_RegBANK_DataBUS_In),
                .o_q        (w_q[i]),
                .o_next     (w_nq[i]),
                .o_next_flag(w_nf[i])
            );
        end else begin : g_empty
            assign w_q[i]  = '0;
            assign w_nq[i] = '0;
            assign w_nf[i] = 1'b0;
        end
    end

    always_ff @(posedge SC_RegBANK_CLOCK_50 or negedge SC_RegBANK_Reset_InLow)
        if (!SC_RegBANK_Reset_InLow) r_flag <= 1'b0;
        else if (w_wr_ok) r_flag <= w_nf[SC_RegBANK_WrAddr_In];

    assign w_fwd_a = BYPASS && w_wr_ok && SC_RegBANK_RdAddrA_In == SC_RegBANK_WrAddr_In;
    assign w_fwd_b = BYPASS && w_wr_ok && SC_RegBANK_RdAddrB_In == SC_RegBANK_WrAddr_In;

    assign SC_RegBANK_DataA_Out = w_fwd_a ? w_nq[SC_RegBANK_WrAddr_In] : w_q[SC_RegBANK_RdAddrA_In];
    assign SC_RegBANK_DataB_Out = w_fwd_b ? w_nq[SC_RegBANK_WrAddr_In] : w_q[SC_RegBANK_RdAddrB_In];
    assign SC_RegBANK_ZeroA_Out = SC_RegBANK_DataA_Out == '0;
    assign SC_RegBANK_Flag_Out  = r_flag;
endmodule

// File: tb/tb_sc_reg_bank.sv
// tb_sc_reg_bank: table-driven scoreboard bench for sc_reg_bank (4-reg and 3-reg instances).
module tb_sc_reg_bank;
    import sc_regbank_pkg::*;

    typedef struct {
        logic       we_n;
        logic [1:0] mode;
        logic [1:0] wa;
        logic [7:0] din;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ez;
        logic       ef;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0, we_n = 1'b1, we3_n = 1'b1;
    logic [1:0] mode = MODE_LOAD, wa = '0, ra = '0, rb = '0;
    logic [7:0] din = '0;
    logic [7:0] a4, b4, a3, b3;
    logic       z4, f4, z3, f3;
    int         n_vec = 0, n_err = 0;
    vec_t       tbl[11];
    vec_t       sb[$];

`ifdef SC_REGBANK_BYPASS_EN
    localparam logic [7:0] RDW_EXP = 8'h11;
`else
    localparam logic [7:0] RDW_EXP = 8'h10;
`endif

    always #5 clk = ~clk;

    sc_reg_bank #(.DATAWIDTH_BUS(8), .NREGS(4), .ADDRWIDTH(2)) dut (
        .SC_RegBANK_CLOCK_50   (clk),
        .SC_RegBANK_Reset_InLow(rst_n),
        .SC_RegBANK_Write_InLow(we_n),
        .SC_RegBANK_Mode_In    (mode),
        .SC_RegBANK_WrAddr_In  (wa),
        .SC_RegBANK_DataBUS_In (din),
        .SC_RegBANK_RdAddrA_In (ra),
        .SC_RegBANK_RdAddrB_In (rb),
        .SC_RegBANK_DataA_Out  (a4),
        .SC_RegBANK_DataB_Out  (b4),
        .SC_RegBANK_ZeroA_Out  (z4),
        .SC_RegBANK_Flag_Out   (f4)
    );

    sc_reg_bank #(.DATAWIDTH_BUS(8), .NREGS(3), .ADDRWIDTH(2)) dut3 (
        .SC_RegBANK_CLOCK_50   (clk),
        .SC_RegBANK_Reset_InLow(rst_n),
        .SC_RegBANK_Write_InLow(we3_n),
        .SC_RegBANK_Mode_In    (mode),
        .SC_RegBANK_WrAddr_In  (wa),
        .SC_RegBANK_DataBUS_In (din),
        .SC_RegBANK_RdAddrA_In (ra),
        .SC_RegBANK_RdAddrB_In (rb),
        .SC_RegBANK_DataA_Out  (a3),
        .SC_RegBANK_DataB_Out  (b3),
        .SC_RegBANK_ZeroA_Out  (z3),
        .SC_RegBANK_Flag_Out   (f3)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        we_n = v.we_n; mode = v.mode; wa = v.wa; din = v.din; ra = v.ra; rb = v.rb;
        sb.push_back(v);
        @(posedge clk);
        #1 we_n = 1'b1;
        #1 e = sb.pop_front();
        chk($sformatf("vec%0d A", idx), a4, e.ea);
        chk($sformatf("vec%0d B", idx), b4, e.eb);
        chk($sformatf("vec%0d ZeroA", idx), {7'b0, z4}, {7'b0, e.ez});
        chk($sformatf("vec%0d Flag", idx), {7'b0, f4}, {7'b0, e.ef});
    endtask

    task automatic op(input bit on3, input logic [1:0] m, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        mode = m; wa = a; din = d;
        if (on3) we3_n = 1'b0; else we_n = 1'b0;
        @(posedge clk);
        #1 we_n = 1'b1; we3_n = 1'b1;
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, MODE_LOAD, 2'd2, 8'hA5, 2'd2, 2'd1, 8'hA5, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, MODE_LOAD, 2'd1, 8'h3C, 2'd2, 2'd1, 8'hA5, 8'h3C, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, MODE_LOAD, 2'd0, 8'hFE, 2'd0, 2'd2, 8'hFE, 8'hA5, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, MODE_INC,  2'd0, 8'h00, 2'd0, 2'd2, 8'hFF, 8'hA5, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, MODE_INC,  2'd0, 8'h00, 2'd0, 2'd1, 8'h00, 8'h3C, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, MODE_LOAD, 2'd0, 8'h77, 2'd0, 2'd1, 8'h00, 8'h3C, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, MODE_LOAD, 2'd3, 8'h81, 2'd3, 2'd0, 8'h81, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, MODE_SHL,  2'd3, 8'h00, 2'd3, 2'd2, 8'h02, 8'hA5, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, MODE_SHR,  2'd3, 8'hFF, 2'd3, 2'd3, 8'h01, 8'h01, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, MODE_SHR,  2'd3, 8'h00, 2'd3, 2'd1, 8'h00, 8'h3C, 1'b1, 1'b1};
        tbl[10] = '{1'b0, MODE_SHR,  2'd3, 8'h00, 2'd1, 2'd3, 8'h3C, 8'h00, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset A", a4, 8'h00);
        chk("reset ZeroA", {7'b0, z4}, 8'h01);
        chk("reset Flag", {7'b0, f4}, 8'h00);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i], i);

        // 3-register instance: address 3 does not exist
        op(1'b1, MODE_LOAD, 2'd2, 8'h77);
        op(1'b1, MODE_LOAD, 2'd0, 8'hFF);
        op(1'b1, MODE_INC, 2'd0, 8'h00);
        chk("b3 inc wrap flag", {7'b0, f3}, 8'h01);
        op(1'b1, MODE_LOAD, 2'd3, 8'h55);
        ra = 2'd3; rb = 2'd2;
        #1;
        chk("b3 rd oob A", a3, 8'h00);
        chk("b3 rd oob ZeroA", {7'b0, z3}, 8'h01);
        chk("b3 r2 kept", b3, 8'h77);
        chk("b3 flag held", {7'b0, f3}, 8'h01);
        rb = 2'd0;
        #1 chk("b3 r0 kept", b3, 8'h00);

        // read during write to the same register
        op(1'b0, MODE_LOAD, 2'd1, 8'h10);
        @(negedge clk);
        we_n = 1'b0; mode = MODE_INC; wa = 2'd1; ra = 2'd1; rb = 2'd2;
        #1;
        chk("rdw same cycle A", a4, RDW_EXP);
        chk("rdw same cycle ZeroA", {7'b0, z4}, 8'h00);
        chk("rdw other B", b4, 8'hA5);
        @(posedge clk);
        #1 we_n = 1'b1;
        #1;
        chk("rdw next cycle A", a4, 8'h11);
        chk("rdw flag", {7'b0, f4}, 8'h00);

        // asynchronous reset mid-cycle, strobe held during reset
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst A", a4, 8'h00);
        chk("async rst B", b4, 8'h00);
        chk("async rst ZeroA", {7'b0, z4}, 8'h01);
        chk("async rst Flag3", {7'b0, f3}, 8'h00);
        we_n = 1'b0; mode = MODE_LOAD; wa = 2'd1; din = 8'h99;
        @(posedge clk);
        #1 chk("strobe in reset", a4, 8'h00);
        @(negedge clk);
        we_n = 1'b1; rst_n = 1'b1;
        @(posedge clk);
        #1 chk("after reset A", a4, 8'h00);
        op(1'b0, MODE_LOAD, 2'd1, 8'h5A);
        chk("load after reset", a4, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
